regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper.sv | 104 ++++++++++
 tb/tb_regfile_dumper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dumper.sv
// regfile_dumper: streams registers 0..NUM_REGS-2 out over a valid/ready port, or zeroes them.
// Define REGDUMP_CHECKSUM_EN to append a final beat carrying the XOR of all dumped words.
module regfile_dumper #(
  parameter int REG_WIDTH = 64,
  parameter int NUM_REGS  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear_mode,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_REGS)-1:0] ReadRegister,
  input  logic [REG_WIDTH-1:0]        ReadData,
  output logic                        RegWrite,
  output logic [$clog2(NUM_REGS)-1:0] WriteRegister,
  output logic [REG_WIDTH-1:0]        WriteData,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [REG_WIDTH-1:0]        dout_data,
  output logic [$clog2(NUM_REGS)-1:0] dout_index,
  output logic                        dout_last
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 2);
  localparam logic [IW-1:0] TOP  = IW'(NUM_REGS - 1);
  typedef enum logic [2:0] {IDLE, READ, SEND, CLEAR, DONE} state_t;
  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        dout_index_q;
  logic [REG_WIDTH-1:0] dout_data_q;
  logic                 last_q;
`ifdef REGDUMP_CHECKSUM_EN
  logic [REG_WIDTH-1:0] csum_q;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dout_index_q <= '0;
      dout_data_q  <= '0;
      last_q       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          idx_q   <= '0;
          state_q <= clear_mode ? CLEAR : READ;
`ifdef REGDUMP_CHECKSUM_EN
          csum_q  <= '0;
`endif
        end
        READ: begin
          dout_data_q  <= ReadData;
          dout_index_q <= idx_q;
          state_q      <= SEND;
`ifdef REGDUMP_CHECKSUM_EN
          last_q       <= 1'b0;
          csum_q       <= csum_q ^ ReadData;
`else
          last_q       <= idx_q == LAST;
`endif
        end
        SEND: if (dout_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          // The checksum beat is loaded straight into the output register, so X31 is never read.
          if (idx_q == TOP) state_q <= DONE;
          else if (idx_q == LAST) begin
            idx_q        <= TOP;
            dout_data_q  <= csum_q;
            dout_index_q <= TOP;
            last_q       <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= READ;
          end
`else
          if (idx_q == LAST) state_q <= DONE;
          else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= READ;
          end
`endif
        end
        CLEAR: if (idx_q == LAST) state_q <= DONE;
               else idx_q <= idx_q + 1'b1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign ReadRegister  = state_q == READ ? idx_q : '0;
  assign RegWrite      = state_q == CLEAR;
  assign WriteRegister = RegWrite ? idx_q : '0;
  assign WriteData     = '0;
  assign dout_valid    = state_q == SEND;
  assign dout_data     = dout_data_q;
  assign dout_index    = dout_index_q;
  assign dout_last     = dout_valid & last_q;
endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: table-driven dump/clear operations against a behavioural register file.
module tb_regfile_dumper;
  localparam int W = 64;
  localparam int N = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB = N - 1 + CS;
  localparam logic [W-1:0] K = 64'h0000010204080001;

  logic clk = 0, reset = 0, start = 0, clear_mode = 0, dout_ready = 1;
  logic busy, done, RegWrite, dout_valid, dout_last;
  logic [4:0] ReadRegister, WriteRegister, dout_index;
  logic [W-1:0] ReadData, WriteData, dout_data;

  regfile_dumper #(.REG_WIDTH(W), .NUM_REGS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_mode(clear_mode),
    .busy(busy), .done(done), .ReadRegister(ReadRegister), .ReadData(ReadData),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_index(dout_index), .dout_last(dout_last)
  );

  logic [W-1:0] rf [N];
  logic [W-1:0] expv [N];
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0, x31 = 0, start_edge = 0, load_kind = 0;
  bit rand_mode = 0;
  int bi[$], bt[$], wa[$], wt[$];
  logic [W-1:0] bd[$], wd[$];
  bit bl[$];
  logic pv = 0, pr = 0;
  logic [W-1:0] pd = '0;
  logic [4:0] pi = '0;

  typedef struct {
    int preload;
    bit clear;
    bit rnd;
    bit poke;
    int nb;
    int nw;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_kind == 1) for (int i = 0; i < N; i++) rf[i] <= W'(i);
    else if (load_kind == 2) for (int i = 0; i < N; i++) rf[i] <= W'(i) * K;
    else if (RegWrite) rf[WriteRegister] <= WriteData;
  end
  assign ReadData = rf[ReadRegister];

  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (dout_valid && dout_ready) begin
        bi.push_back(int'(dout_index));
        bd.push_back(dout_data);
        bl.push_back(dout_last);
        bt.push_back(cyc + 1);
      end
      if (RegWrite) begin
        wa.push_back(int'(WriteRegister));
        wd.push_back(WriteData);
        wt.push_back(cyc + 1);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (ReadRegister == 5'd31 || (RegWrite && WriteRegister == 5'd31)) x31 <= x31 + 1;
      if (pv && !pr) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout_data, pd);
        chk("hold_index", dout_index, pi);
      end
    end
    pv <= reset & dout_valid;
    pr <= dout_ready;
    pd <= dout_data;
    pi <= dout_index;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_data"}, dout_data, 0);
    chk({tag, "_index"}, dout_index, 0);
    chk({tag, "_last"}, dout_last, 0);
    chk({tag, "_regwrite"}, RegWrite, 0);
    chk({tag, "_readreg"}, ReadRegister, 0);
    chk({tag, "_writereg"}, WriteRegister, 0);
    chk({tag, "_writedata"}, WriteData, 0);
  endtask

  task automatic run_op(input vec_t v);
    int k, d0;
    logic [W-1:0] x;
    if (v.preload != 0) begin
      load_kind = v.preload;
      @(posedge clk);
      #1;
      load_kind = 0;
      for (int i = 0; i < N; i++) expv[i] = v.preload == 1 ? W'(i) : W'(i) * K;
    end
    rand_mode = v.rnd;
    @(negedge clk);
    bi.delete(); bd.delete(); bl.delete(); bt.delete();
    wa.delete(); wd.delete(); wt.delete();
    d0 = done_cnt;
    clear_mode = v.clear;
    start = 1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 0;
    clear_mode = 0;
    k = 0;
    while (!done && k < 600) begin
      @(negedge clk);
      k++;
      if (v.poke && k == 15) begin
        start = 1;
        clear_mode = 1;
      end else if (v.poke && k == 16) begin
        start = 0;
        clear_mode = 0;
      end
    end
    chk("done_timeout", k < 600, 1);
    @(negedge clk);
    rand_mode = 0;
    chk("busy_after", busy, 0);
    chk("done_once", done_cnt - d0, 1);
    chk("beat_count", bi.size(), v.nb);
    chk("write_count", wa.size(), v.nw);
    chk("x31_touched", x31, 0);
    x = '0;
    for (int j = 0; j < N - 1; j++) x ^= expv[j];
    for (int j = 0; j < bi.size() && j < v.nb; j++) begin
      chk("beat_index", bi[j], j);
      chk("beat_data", bd[j], j < N - 1 ? expv[j] : x);
      chk("beat_last", bl[j], j == v.nb - 1);
      if (!v.rnd && j < N - 1) chk("beat_time", bt[j], start_edge + 2 + 2 * j);
    end
    for (int j = 0; j < wa.size() && j < v.nw; j++) begin
      chk("clr_addr", wa[j], j);
      chk("clr_data", wd[j], 0);
      chk("clr_time", wt[j], start_edge + 1 + j);
    end
    if (v.clear) for (int i = 0; i < N - 1; i++) expv[i] = '0;
  endtask

  task automatic reset_mid_dump();
    int k, d0;
    @(negedge clk);
    start = 1;
    clear_mode = 0;
    @(negedge clk);
    start = 0;
    k = 0;
    while (!(dout_valid && dout_index == 5'd10) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("beat10_timeout", k < 200, 1);
    d0 = done_cnt;
    #2;
    reset = 0;
    #1;
    chk_zero("async_rst");
    repeat (3) @(negedge clk);
    chk_zero("held_rst");
    chk("no_done_on_abort", done_cnt - d0, 0);
    reset = 1;
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 0, NB, 0};
    vecs[1] = '{1, 0, 1, 0, NB, 0};
    vecs[2] = '{2, 1, 0, 0, 0, N - 1};
    vecs[3] = '{0, 0, 1, 0, NB, 0};
    vecs[4] = '{2, 0, 0, 1, NB, 0};
    vecs[5] = '{1, 0, 0, 0, NB, 0};
    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    reset = 1;
    for (int v = 0; v < 5; v++) run_op(vecs[v]);
    reset_mid_dump();
    run_op(vecs[5]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
